// File: rtl/md_unit.sv
// rtl/md_unit.sv - iterative multiply/divide unit owning the HI/LO register pair
module md_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // Latched operation context; the datapath needs no reset because every
  // field is loaded on the accept edge before it is used.
  logic               op_div;
  logic               neg_main;
  logic               neg_rem;
  logic               div_zero;
  logic [WIDTH-1:0]   a_orig;
  logic [WIDTH-1:0]   operand;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;

  // Control strobes decoded from state and request inputs
  logic accept;
  logic wr_mthi;
  logic wr_mtlo;
  logic last_iter;
  logic writeback;

  // Operand magnitudes for the signed ops (op[0]=0 means signed)
  logic             op_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  // One iteration of each algorithm
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_step;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] div_step;

  // Sign-corrected results presented at writeback
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  // Operand sign handling: signed ops iterate on magnitudes
  always_comb begin
    op_signed = ~op[0];
    a_neg     = op_signed & a[WIDTH-1];
    b_neg     = op_signed & b[WIDTH-1];
    a_mag     = a_neg ? (~a + 1'b1) : a;
    b_mag     = b_neg ? (~b + 1'b1) : b;
  end

  // Shift-add multiply step and restoring divide step on the shared accumulator
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    mul_step  = {mul_sum, acc[WIDTH-1:1]};
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_shift - {1'b0, operand};
    div_ge    = ~div_diff[WIDTH];
    div_rem   = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    div_step  = {div_rem, acc[WIDTH-2:0], div_ge};
  end

  // Final sign correction: product/quotient follow the sign xor, remainder the dividend
  always_comb begin
    prod_fix = neg_main ? (~acc + 1'b1) : acc;
    quot_fix = neg_main ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
    rem_fix  = neg_rem ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; cancel wins over everything outside IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start && !cancel && !op[2]) state_nxt = S_RUN;
      S_RUN: begin
        if (cancel)         state_nxt = S_IDLE;
        else if (last_iter) state_nxt = S_FIX;
      end
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output/strobe decode for the current state
  always_comb begin
    accept    = (state == S_IDLE) && start && !cancel && !op[2];
    wr_mthi   = (state == S_IDLE) && start && !cancel && (op == 3'd4);
    wr_mtlo   = (state == S_IDLE) && start && !cancel && (op == 3'd5);
    last_iter = (cnt == CW'(WIDTH - 1));
    writeback = (state == S_FIX) && !cancel;
  end

  // Registered handshake outputs so busy/done have no input-to-output path
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_nxt != S_IDLE);
      done <= writeback;
    end
  end

  // Datapath: load on accept, iterate once per RUN cycle
  always_ff @(posedge clk) begin
    if (accept) begin
      op_div   <= op[1];
      neg_main <= a_neg ^ b_neg;
      neg_rem  <= a_neg;
      div_zero <= (b == '0);
      a_orig   <= a;
      cnt      <= '0;
      if (op[1]) begin
        operand <= b_mag;
        acc     <= {{WIDTH{1'b0}}, a_mag};
      end else begin
        operand <= a_mag;
        acc     <= {{WIDTH{1'b0}}, b_mag};
      end
    end else if (state == S_RUN) begin
      cnt <= cnt + 1'b1;
      acc <= op_div ? div_step : mul_step;
    end
  end

  // HI/LO architectural registers: MTHI/MTLO in IDLE, MULT/DIV results at FIX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
    end else if (writeback) begin
      if (!op_div) begin
        hi <= prod_fix[2*WIDTH-1:WIDTH];
        lo <= prod_fix[WIDTH-1:0];
      end else if (div_zero) begin
        hi <= a_orig;
        lo <= '1;
      end else begin
        hi <= rem_fix;
        lo <= quot_fix;
      end
    end else begin
      if (wr_mthi) hi <= a;
      if (wr_mtlo) lo <= a;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - scoreboard bench for md_unit against an arithmetic reference model
module tb_md_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        cancel;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] exp_q[$];
  logic [31:0] cur_hi = 32'd0;
  logic [31:0] cur_lo = 32'd0;

  md_unit #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .cancel (cancel),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  // Reference: {hi, lo} computed with plain 64-bit and C-style signed arithmetic
  function automatic logic [63:0] ref_model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint p;
    int     sx;
    int     sy;
    sx = x;
    sy = y;
    case (o)
      3'd0: begin
        p = longint'(sx) * longint'(sy);
        return p;
      end
      3'd1: return {32'd0, x} * {32'd0, y};
      3'd2: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        return {32'(sx % sy), 32'(sx / sy)};
      end
      3'd3: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding result
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1, required no pending result");
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("result_hi", {32'd0, hi}, {32'd0, e[63:32]});
        check("result_lo", {32'd0, lo}, {32'd0, e[31:0]});
      end
    end
  end

  // Drive one request for a single cycle starting at a negedge
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input bit push);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    if (push) exp_q.push_back(ref_model(o, x, y));
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 3'($urandom);
    a     = $urandom;
    b     = $urandom;
  endtask

  // Wait for busy to fall, checking the 33-cycle busy window; ends at a negedge in the done cycle
  task automatic finish_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input int elapsed);
    int cyc;
    cyc = elapsed;
    @(negedge clk);
    while (busy && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    check("busy_cycles", 64'(cyc), 64'd33);
    {cur_hi, cur_lo} = ref_model(o, x, y);
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    issue(o, x, y, 1'b1);
    finish_op(o, x, y, 0);
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    cancel = 1'b0;
    op     = 3'd0;
    a      = 32'd0;
    b      = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // MTHI / MTLO single-cycle writes
    issue(3'd4, 32'h1234, 32'd0, 1'b0);
    cur_hi = 32'h1234;
    check("mthi_hi", 64'(hi), 64'(cur_hi));
    check("mthi_busy", 64'(busy), 64'd0);
    @(negedge clk);
    issue(3'd5, 32'h5678, 32'd0, 1'b0);
    cur_lo = 32'h5678;
    check("mtlo_lo", 64'(lo), 64'(cur_lo));
    @(negedge clk);

    // Reserved op is a no-op
    issue(3'd6, 32'hDEAD, 32'hBEEF, 1'b0);
    check("noop_busy", 64'(busy), 64'd0);
    check("noop_hilo", {hi, lo}, {cur_hi, cur_lo});
    @(negedge clk);

    // cancel in IDLE blocks acceptance of start
    cancel = 1'b1;
    issue(3'd0, 32'd5, 32'd6, 1'b0);
    check("idle_cancel_busy", 64'(busy), 64'd0);
    @(negedge clk);
    issue(3'd4, 32'hFFFF, 32'd0, 1'b0);
    cancel = 1'b0;
    check("idle_cancel_mthi", 64'(hi), 64'(cur_hi));
    @(negedge clk);

    // Directed arithmetic cases, each issued back-to-back in the previous done cycle
    run_op(3'd0, 32'hFFFF_FFFD, 32'd7);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2);
    run_op(3'd3, 32'd100, 32'd0);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(3'd2, 32'hFFFF_FF9C, 32'd0);
    run_op(3'd3, 32'hFFFF_FFF0, 32'd7);

    // Explicit back-to-back acceptance in the done cycle
    check("b2b_done", 64'(done), 64'd1);
    issue(3'd0, 32'd5, 32'hFFFF_FFFA, 1'b1);
    check("b2b_busy", 64'(busy), 64'd1);
    finish_op(3'd0, 32'd5, 32'hFFFF_FFFA, 0);

    // MTLO while busy is ignored
    issue(3'd1, 32'h0001_0003, 32'h0002_0005, 1'b1);
    repeat (5) @(negedge clk);
    start = 1'b1;
    op    = 3'd5;
    a     = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_mtlo_lo", 64'(lo), 64'(cur_lo));
    check("busy_mtlo_hi", 64'(hi), 64'(cur_hi));
    finish_op(3'd1, 32'h0001_0003, 32'h0002_0005, 5);
    @(negedge clk);

    // cancel at iteration 10
    issue(3'd2, 32'h7654_3210, 32'd13, 1'b0);
    repeat (10) @(negedge clk);
    cancel = 1'b1;
    @(posedge clk);
    #1;
    cancel = 1'b0;
    check("cancel_run_busy", 64'(busy), 64'd0);
    check("cancel_run_hilo", {hi, lo}, {cur_hi, cur_lo});
    repeat (40) @(negedge clk);

    // cancel in the writeback cycle suppresses the write and done
    issue(3'd0, 32'h0000_1111, 32'h0000_2222, 1'b0);
    repeat (33) @(negedge clk);
    cancel = 1'b1;
    @(posedge clk);
    #1;
    cancel = 1'b0;
    check("cancel_fix_busy", 64'(busy), 64'd0);
    check("cancel_fix_hilo", {hi, lo}, {cur_hi, cur_lo});
    repeat (3) @(negedge clk);

    // Randomized back-to-back operations
    for (int i = 0; i < 24; i++) begin
      logic [2:0]  ro;
      logic [31:0] rx;
      logic [31:0] ry;
      ro = 3'($urandom_range(0, 3));
      rx = pick();
      ry = pick();
      run_op(ro, rx, ry);
    end

    // Asynchronous reset mid-DIV
    run_op(3'd1, 32'd3, 32'd5);
    @(negedge clk);
    issue(3'd2, 32'h1357_9BDF, 32'd9, 1'b0);
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_hi", 64'(hi), 64'd0);
    check("async_rst_lo", 64'(lo), 64'd0);
    check("async_rst_busy", 64'(busy), 64'd0);
    cur_hi = 32'd0;
    cur_lo = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(3'd3, 32'd1000, 32'd7);

    repeat (3) @(negedge clk);
    check("pending_results", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
